lutram_fifo: RTL and testbench
==============================

# lutram_fifo

Synchronous ready/valid FIFO built around the inferable LUT-RAM block `AsyncDpRam`, which it instantiates as its storage. The FIFO owns the write port, the read address and all pointer and occupancy state. It sits directly upstream of that RAM and gives streaming producers and consumers a drop-in buffer with first-word fall-through, so the RAM is never driven by hand.

## Interface
- `ADDR_WIDTH`, 4: RAM address width.
- `DATA_DEPTH`, 16: number of RAM entries; 2 ≤ `DATA_DEPTH` ≤ 2**`ADDR_WIDTH`; need not be a power of two.
- `DATA_WIDTH`, 32: payload width.
- `Clk_CI`  in  1  clock; all state updates on the rising edge.
- `Rst_RBI`  in  1  reset, synchronous, active-low.
- `Flush_SI`  in  1  synchronous clear of all FIFO contents.
- `In_Valid_SI`  in  1  producer has data.
- `In_Ready_SO`  out  1  FIFO accepts data; a push happens when valid and ready are both high.
- `In_Data_DI`  in  `DATA_WIDTH`  push payload.
- `Out_Valid_SO`  out  1  head entry available.
- `Out_Ready_SI`  in  1  consumer takes data; a pop happens when valid and ready are both high.
- `Out_Data_DO`  out  `DATA_WIDTH`  head payload; don't-care while `Out_Valid_SO` = 0.
- `Fill_DO`  out  `ADDR_WIDTH`+1  current occupancy.

## Operation
- Write pointer and read pointer are each `ADDR_WIDTH` wide. Each increments by 1 and wraps from `DATA_DEPTH`-1 to 0; the wrap is an explicit compare, not a binary overflow.
- RAM occupancy counter, width `ADDR_WIDTH`+1:
  - +1 on push only, −1 on pop only.
  - Unchanged on simultaneous push and pop.
- `In_Ready_SO` = (total occupancy < capacity) and not in reset.
  - When full, a push is refused even if a pop happens in the same cycle. There is no pass-through.
- Push: RAM write enable = push; write address = write pointer; write data = `In_Data_DI`.
- Pop: the read pointer advances, and the next entry appears combinationally through the RAM's asynchronous read.
- Flush:
  - Zeroes both pointers, the counter and the output-register state.
  - Has priority over a push or pop in the same cycle; that push or pop is lost.
  - RAM contents are not cleared.
- Reset (`Rst_RBI` = 0 at an edge) has the same effect as flush. While reset is held:
  - `In_Ready_SO` = 0, `Out_Valid_SO` = 0, `Fill_DO` = 0.
  - The output register (when present) = 0.
- Reset asserted mid-stream discards all entries. The first push after reset deasserts lands at RAM address 0.

## Timing
- Without the output register:
  - Push at edge N → `Out_Valid_SO` = 1 and `Out_Data_DO` valid in cycle N+1.
  - `Fill_DO` updates in cycle N+1.
  - Capacity = `DATA_DEPTH`.
- With the output register: push into an empty FIFO at edge N → `Out_Valid_SO` = 1 in cycle N+2.
- Sustained throughput is 1 push and 1 pop per cycle in both configurations.
- `Out_Data_DO` stays stable while `Out_Valid_SO` = 1 and `Out_Ready_SI` = 0.

## Configuration
- Macro: `LUTRAM_FIFO_OUT_REG_EN`.
- Defined: adds a registered output stage.
  - Two-state machine: `OR_EMPTY` → `OR_VALID` when the register loads from the RAM head.
  - `OR_VALID` → `OR_EMPTY` on pop when the RAM is empty.
  - `OR_VALID` → `OR_VALID` on pop when the RAM is non-empty; it reloads in the same cycle.
  - The register loads whenever (`OR_EMPTY` or pop) and the RAM is non-empty; each load advances the read pointer.
  - Capacity = `DATA_DEPTH`+1; `Fill_DO` includes the register entry.
  - `Out_Data_DO` is driven only by a flop, which cuts the RAM read path.
- Undefined: `Out_Data_DO` is driven directly by the RAM read data; `Out_Valid_SO` = (counter ≠ 0).

## Structure
- Package `lutram_fifo_pkg`:
  - Output-register state enum `or_state_e` (`OR_EMPTY`, `OR_VALID`).
  - Pointer-increment-with-wrap function, taking the pointer and the depth.
- Sub-module: `AsyncDpRam`, instantiated once with the same three parameters. No other hierarchy.
- Simulation-only assertions, excluded from synthesis:
  - `DATA_DEPTH` within bounds.
  - No push when `In_Ready_SO` = 0.
  - `Fill_DO` never exceeds capacity.

## Test plan
1. Reset, then push 0xA5A5_0001 with `Out_Ready_SI` = 0 → `Out_Valid_SO` = 1 after 1 cycle (2 cycles with `_EN`), data 0xA5A5_0001, `Fill_DO` = 1.
2. `DATA_DEPTH` = 12, `ADDR_WIDTH` = 4, push 0..11 without popping → `In_Ready_SO` = 0 and `Fill_DO` = 12 (13 with `_EN` after one more push).
   - Then pop all → values 0..11 in order; write pointer has wrapped to 0.
3. Full FIFO, simultaneous `In_Valid_SI` and `Out_Ready_SI` for one cycle → pop only, `Fill_DO` decrements by 1, the pushed word is not stored.
4. Continuous stream of 100 incrementing words with both sides always ready → one word out per cycle, no gaps after initial latency, `Fill_DO` constant.
5. Three entries stored, `Flush_SI` asserted together with a push → next cycle `Fill_DO` = 0 and `Out_Valid_SO` = 0.
   - A following push of 0x77 reads back 0x77.
6. `Rst_RBI` pulled low for 1 cycle mid-stream with 5 entries stored → `Fill_DO` = 0 and `In_Ready_SO` = 0 during reset, no stale data emitted afterwards.

Source files
------------

// File: rtl/lutram_fifo_pkg.sv
// lutram_fifo_pkg
// Shared types and helpers for the LUT-RAM backed FIFO.
//   or_state_e    : state of the optional registered output stage
//   ptr_wrap_incr : increment a RAM pointer, wrapping at an arbitrary depth
package lutram_fifo_pkg;

  // Output register holds nothing (OR_EMPTY) or the current head word (OR_VALID).
  typedef enum logic [0:0] {
    OR_EMPTY = 1'b0,
    OR_VALID = 1'b1
  } or_state_e;

  // Depth need not be a power of two, so the wrap is an explicit compare
  // against depth-1 rather than relying on binary overflow.
  function automatic int unsigned ptr_wrap_incr(input int unsigned ptr,
                                                input int unsigned depth);
    int unsigned nxt;
    if (ptr == (depth - 32'd1)) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lutram_fifo_async_dp_ram.sv
// AsyncDpRam
// Inferable LUT-RAM: one synchronous write port, one asynchronous read port.
// Contents are never reset.
// Ports:
//   Clk_CI     in  clock
//   WrEn_SI    in  write enable
//   WrAddr_DI  in  write address
//   WrData_DI  in  write data
//   RdAddr_DI  in  read address
//   RdData_DO  out read data (combinational from RdAddr_DI)
module AsyncDpRam #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clk_CI,
  input  logic                  WrEn_SI,
  input  logic [ADDR_WIDTH-1:0] WrAddr_DI,
  input  logic [DATA_WIDTH-1:0] WrData_DI,
  input  logic [ADDR_WIDTH-1:0] RdAddr_DI,
  output logic [DATA_WIDTH-1:0] RdData_DO
);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  // Storage write; no reset so the array maps onto distributed RAM.
  always_ff @(posedge Clk_CI) begin
    if (WrEn_SI) begin
      mem_q[WrAddr_DI] <= WrData_DI;
    end else begin
      mem_q[WrAddr_DI] <= mem_q[WrAddr_DI];
    end
  end

  assign RdData_DO = mem_q[RdAddr_DI];

endmodule

// File: rtl/lutram_fifo.sv
// lutram_fifo
// Ready/valid FIFO with first-word fall-through on top of AsyncDpRam.
// Owns the RAM write port, the read address and all pointer/occupancy state.
// Optional feature macro: LUTRAM_FIFO_OUT_REG_EN adds a registered output
// stage (capacity DATA_DEPTH+1, Out_Data_DO driven only by a flop).
// Ports:
//   Clk_CI        in  clock, rising edge
//   Rst_RBI       in  synchronous active-low reset
//   Flush_SI      in  synchronous clear of all contents
//   In_Valid_SI   in  producer valid
//   In_Ready_SO   out FIFO can accept (push = valid & ready)
//   In_Data_DI    in  push payload
//   Out_Valid_SO  out head entry available
//   Out_Ready_SI  in  consumer ready (pop = valid & ready)
//   Out_Data_DO   out head payload
//   Fill_DO       out total occupancy
module lutram_fifo
  import lutram_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Flush_SI,
  input  logic                  In_Valid_SI,
  output logic                  In_Ready_SO,
  input  logic [DATA_WIDTH-1:0] In_Data_DI,
  output logic                  Out_Valid_SO,
  input  logic                  Out_Ready_SI,
  output logic [DATA_WIDTH-1:0] Out_Data_DO,
  output logic [ADDR_WIDTH:0]   Fill_DO
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(32'd1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;      // entries held in the RAM only
  logic                  push_s;
  logic                  pop_s;
  logic                  rd_adv_s;          // RAM head consumed this cycle
  logic                  ram_empty_s;
  logic                  ram_we_s;
  logic [DATA_WIDTH-1:0] ram_rd_data_s;

  assign ram_empty_s = (cnt_q == '0);
  assign push_s      = In_Valid_SI && In_Ready_SO;
  // A push in a flush cycle is discarded, so it must not touch the RAM either.
  assign ram_we_s    = push_s && !Flush_SI;

  AsyncDpRam #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_DEPTH (DATA_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) i_ram (
    .Clk_CI    (Clk_CI),
    .WrEn_SI   (ram_we_s),
    .WrAddr_DI (wr_ptr_q),
    .WrData_DI (In_Data_DI),
    .RdAddr_DI (rd_ptr_q),
    .RdData_DO (ram_rd_data_s)
  );

`ifdef LUTRAM_FIFO_OUT_REG_EN
  localparam logic [ADDR_WIDTH:0] CAPACITY = (ADDR_WIDTH+1)'(DATA_DEPTH + 32'd1);

  or_state_e             or_state_q, or_state_d;
  logic [DATA_WIDTH-1:0] or_data_q, or_data_d;
  logic                  load_s;
  logic [ADDR_WIDTH:0]   fill_s;

  assign fill_s       = cnt_q + (ADDR_WIDTH+1)'(or_state_q == OR_VALID);
  assign In_Ready_SO  = Rst_RBI && (fill_s < CAPACITY);
  assign Out_Valid_SO = Rst_RBI && (or_state_q == OR_VALID);
  assign pop_s        = Out_Valid_SO && Out_Ready_SI;
  // Refill the register whenever it is (or is about to be) free and the RAM has a word.
  assign load_s       = ((or_state_q == OR_EMPTY) || pop_s) && !ram_empty_s;
  assign rd_adv_s     = load_s;
  assign Out_Data_DO  = or_data_q;
  assign Fill_DO      = Rst_RBI ? fill_s : '0;

  // Output-register next state and data.
  always_comb begin
    or_state_d = or_state_q;
    or_data_d  = or_data_q;
    if (Flush_SI) begin
      or_state_d = OR_EMPTY;
      or_data_d  = '0;
    end else begin
      case (or_state_q)
        OR_EMPTY: begin
          if (load_s) begin
            or_state_d = OR_VALID;
            or_data_d  = ram_rd_data_s;
          end else begin
            or_state_d = OR_EMPTY;
          end
        end
        OR_VALID: begin
          if (load_s) begin
            or_state_d = OR_VALID;
            or_data_d  = ram_rd_data_s;
          end else if (pop_s) begin
            or_state_d = OR_EMPTY;
          end else begin
            or_state_d = OR_VALID;
          end
        end
        default: begin
          or_state_d = OR_EMPTY;
        end
      endcase
    end
  end

  // Output-register state machine and data flop.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      or_state_q <= OR_EMPTY;
      or_data_q  <= '0;
    end else begin
      or_state_q <= or_state_d;
      or_data_q  <= or_data_d;
    end
  end
`else
  localparam logic [ADDR_WIDTH:0] CAPACITY = (ADDR_WIDTH+1)'(DATA_DEPTH);

  assign In_Ready_SO  = Rst_RBI && (cnt_q < CAPACITY);
  assign Out_Valid_SO = Rst_RBI && !ram_empty_s;
  assign pop_s        = Out_Valid_SO && Out_Ready_SI;
  assign rd_adv_s     = pop_s;
  assign Out_Data_DO  = ram_rd_data_s;
  assign Fill_DO      = Rst_RBI ? cnt_q : '0;
`endif

  // Pointer and RAM-occupancy next state; flush overrides any transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (Flush_SI) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = ADDR_WIDTH'(ptr_wrap_incr(32'(wr_ptr_q), DATA_DEPTH));
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_adv_s) begin
        rd_ptr_d = ADDR_WIDTH'(ptr_wrap_incr(32'(rd_ptr_q), DATA_DEPTH));
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, rd_adv_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and counter flops.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_depth_bounds: assert property (@(posedge Clk_CI)
    (DATA_DEPTH >= 32'd2) && (DATA_DEPTH <= (32'd1 << ADDR_WIDTH)));
  a_no_push_refused: assert property (@(posedge Clk_CI) ram_we_s |-> In_Ready_SO);
  a_fill_bound: assert property (@(posedge Clk_CI) Fill_DO <= CAPACITY);
`endif

endmodule

// File: tb/tb_lutram_fifo.sv
// Testbench for lutram_fifo: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_lutram_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int DW    = 32;
`ifdef LUTRAM_FIFO_OUT_REG_EN
  localparam int CAP = DEPTH + 1;
  localparam int LAT = 1;
`else
  localparam int CAP = DEPTH;
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW:0]   fill;

  int n_checks = 0;
  int n_fail   = 0;

  lutram_fifo #(
    .ADDR_WIDTH (AW),
    .DATA_DEPTH (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .Clk_CI       (clk),
    .Rst_RBI      (rst_n),
    .Flush_SI     (flush),
    .In_Valid_SI  (in_valid),
    .In_Ready_SO  (in_ready),
    .In_Data_DI   (in_data),
    .Out_Valid_SO (out_valid),
    .Out_Ready_SI (out_ready),
    .Out_Data_DO  (out_data),
    .Fill_DO      (fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mq[$];     // words not yet in the output register
  bit            slot_v = 1'b0;
  logic [DW-1:0] slot_d = '0;
  bit            started = 1'b0;

  function automatic int m_fill();
    return mq.size() + (slot_v ? 1 : 0);
  endfunction

  function automatic bit m_valid();
`ifdef LUTRAM_FIFO_OUT_REG_EN
    return slot_v;
`else
    return mq.size() != 0;
`endif
  endfunction

  function automatic logic [DW-1:0] m_head();
`ifdef LUTRAM_FIFO_OUT_REG_EN
    return slot_d;
`else
    return (mq.size() != 0) ? mq[0] : '0;
`endif
  endfunction

  task automatic model_step();
    bit do_push;
    bit do_pop;
    do_push = rst_n && in_valid && (m_fill() < CAP);
    do_pop  = rst_n && out_ready && m_valid();
    if (!rst_n || flush) begin
      mq.delete();
      slot_v = 1'b0;
    end else begin
`ifdef LUTRAM_FIFO_OUT_REG_EN
      if (do_pop) slot_v = 1'b0;
      // the register refills from words already stored, never from this cycle's push
      if (!slot_v && mq.size() > 0) begin
        slot_d = mq.pop_front();
        slot_v = 1'b1;
      end
`else
      if (do_pop) void'(mq.pop_front());
`endif
      if (do_push) mq.push_back(in_data);
    end
    started = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("cyc_in_ready", in_ready, rst_n && (m_fill() < CAP));
      chk("cyc_out_valid", out_valid, rst_n && m_valid());
      chk("cyc_fill", fill, rst_n ? m_fill() : 0);
      if (rst_n && m_valid()) chk("cyc_out_data", out_data, m_head());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int pv[4] = '{90, 50, 30, 95};
  int pr[4] = '{30, 50, 90, 95};

  initial begin
    repeat (2) step();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill, 0);
    rst_n = 1'b1;
    step();

    // 1: single push, first-word fall-through latency
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    step();
    in_valid = 1'b0;
`ifdef LUTRAM_FIFO_OUT_REG_EN
    chk("t1_valid_early", out_valid, 0);
    step();
`endif
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'hA5A5_0001);
    chk("t1_fill", fill, 1);
    chk("t1_model_fill", m_fill(), 1);
    chk("t1_model_head", m_head(), 32'hA5A5_0001);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_fill", fill, 0);

    // 2: fill to capacity with a non-power-of-two depth
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 32'(i);
      step();
    end
`ifdef LUTRAM_FIFO_OUT_REG_EN
    chk("t2_ready_before_extra", in_ready, 1);
    in_data = 32'h99;
    step();
`endif
    in_valid = 1'b0;
    chk("t2_ready_full", in_ready, 0);
    chk("t2_fill_full", fill, CAP);
    chk("t2_model_fill", m_fill(), CAP);

    // 3: push and pop together while full -> only the pop happens
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t3_fill", fill, CAP - 1);
    chk("t3_ready", in_ready, 1);

    // drain: words 1..11 in order, then the extra word with the register stage
    out_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      chk("t2_pop_valid", out_valid, 1);
      chk("t2_pop_data", out_data, 32'(i));
      step();
    end
`ifdef LUTRAM_FIFO_OUT_REG_EN
    chk("t2_pop_extra", out_data, 32'h99);
    step();
`endif
    out_ready = 1'b0;
    chk("t2_drained_fill", fill, 0);
    chk("t2_drained_valid", out_valid, 0);

    // 4: continuous stream, one word per cycle
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_data = 32'h1000 + 32'(k);
      step();
      if (k >= LAT) begin
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, 32'h1000 + 32'(k - LAT));
        chk("t4_fill", fill, LAT + 1);
      end
    end
    in_valid = 1'b0;
    repeat (LAT + 1) step();
    out_ready = 1'b0;
    chk("t4_end_fill", fill, 0);

    // 5: flush with a simultaneous push
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 32'(i);
      step();
    end
    flush = 1'b1; in_data = 32'h4;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_fill", fill, 0);
    chk("t5_valid", out_valid, 0);
    in_valid = 1'b1; in_data = 32'h77;
    step();
    in_valid = 1'b0;
`ifdef LUTRAM_FIFO_OUT_REG_EN
    step();
`endif
    chk("t5_valid_77", out_valid, 1);
    chk("t5_data_77", out_data, 32'h77);
    chk("t5_fill_77", fill, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // 6: reset mid-stream with five stored words
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h50 + 32'(i);
      step();
    end
    rst_n = 1'b0; in_data = 32'h5F;
    step();
    chk("t6_rst_fill", fill, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_valid", out_valid, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("t6_after_valid", out_valid, 0);
    chk("t6_after_fill", fill, 0);
    in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
`ifdef LUTRAM_FIFO_OUT_REG_EN
    step();
`endif
    chk("t6_first_data", out_data, 32'h55);
    chk("t6_first_fill", fill, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // randomized traffic in four load profiles, checked by the per-cycle compare
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        in_valid  = ($urandom_range(0, 99) < pv[ph]);
        out_ready = ($urandom_range(0, 99) < pr[ph]);
        in_data   = $urandom();
        flush     = ($urandom_range(0, 99) == 0);
        rst_n     = ($urandom_range(0, 199) != 0);
        step();
      end
    end
    flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
